mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
Iterative, parametrised multiply/divide unit implementing the full RISC-V M-extension set: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Multiplication uses radix-2 shift-add; division uses radix-2 restoring.
- Sits beside the single-cycle ALU in the EX stage. The pipeline stalls while BUSY is high and consumes RESULT when DONE pulses.
- Generalises the ALU's combinational M operations to width XLEN, with correct high-word and signed semantics and a start/done handshake.

Parameters:
XLEN, 32, operand and result width in bits (any even value ≥ 8).
CNT_W, $clog2(XLEN)+1, width of the iteration counter (derived; not overridden).

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RESET  input  1  asynchronous, active-high reset.
START  input  1  request; sampled only while BUSY=0.
SELECT  input  3  operation, RISC-V funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
DATA1  input  XLEN  rs1 operand (multiplicand / dividend).
DATA2  input  XLEN  rs2 operand (multiplier / divisor).
BUSY  output  1  high while an operation is in progress.
DONE  output  1  one-cycle pulse; RESULT is valid in that cycle.
RESULT  output  XLEN  result register.

Behaviour:
- Clock and reset: one clock, CLK. RESET is asynchronous and active-high.
- Reset values: state=IDLE, BUSY=0, DONE=0, RESULT=0, counter=0, and all internal operand/accumulator registers = 0.
- Reset mid-operation: abort immediately with no DONE pulse; return to IDLE.
- FSM states:
  - IDLE: BUSY=0. If START=1 at an edge, capture SELECT, DATA1 and DATA2, latch the sign flags, and convert signed operands to magnitudes. Then:
    - divide special case → FIN;
    - otherwise → CALC with counter=XLEN.
  - CALC: BUSY=1. One iteration per edge; the counter decrements. When the counter reaches 1, the next edge moves to FIN.
    - Multiply: if the multiplier LSB is 1, add the multiplicand to the upper half of the 2·XLEN accumulator; then shift right by 1.
    - Divide: shift the remainder:quotient pair left by 1. Trial-subtract the divisor; if the result is non-negative, keep it and set the quotient LSB.
  - FIN: BUSY=1. Apply the sign correction (two's-complement negate where the signs require it). Register RESULT, pulse DONE, go to IDLE.
- Signedness rules:
  - MULH: signed × signed. MULHSU: signed DATA1 × unsigned DATA2. MULHU: unsigned × unsigned.
  - MUL returns the low XLEN bits of the product; MULH/MULHSU/MULHU return the high XLEN bits.
  - DIV/REM: quotient truncates toward zero; the remainder takes the dividend's sign.
- Divide special cases (resolved without CALC):
  - divisor=0: DIV/DIVU → all ones; REM/REMU → DATA1.
  - DIV/REM with DATA1=most-negative and DATA2=−1: DIV → DATA1; REM → 0.
- Latency, measured from the accepting edge to DONE visible:
  - normal operations: XLEN+1 cycles (33 for XLEN=32);
  - special cases: 1 cycle.
- Handshake:
  - START while BUSY=1 is ignored; captured operands do not change.
  - During the DONE cycle the state is IDLE, so a new START in that cycle is accepted (back-to-back operation, no bubble).
  - RESULT holds its value until the next FIN.
  - The caller must hold inputs valid only in the START cycle.

Optional Feature:
Macro: MDU_EARLY_OUT_EN.
- Defined: in CALC, a multiply whose remaining multiplier bits are all zero aligns the accumulator (shifts right by the remaining count in one step) and moves to FIN at the next edge. Latency is between 2 and XLEN+1 cycles. Division is unaffected.
- Undefined: fixed latency as above.
- RESULT is identical in both builds.

Decomposition:
Package mdu_pkg holds:
- the SELECT encodings as named localparams (OP_MUL … OP_REMU);
- the state encoding (IDLE, CALC, FIN);
- the default XLEN.

One natural sub-module: mdu_div_step, a combinational single restoring-division iteration. Inputs: remainder, quotient, divisor. Outputs: next remainder, next quotient.

Test Plan:
1. MUL, DATA1=20, DATA2=10, START for 1 cycle → BUSY high for 33 cycles; DONE pulses 33 cycles after the accepting edge with RESULT=200 (0x000000C8).
2. MULH −2×3 → 0xFFFFFFFF. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MUL of the same pair → 0x00000001.
3. DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC. REMU 0xFFFFFFF9/2 → 1.
4. DIVU 5/0 → 0xFFFFFFFF. REMU 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same pair → 0. All four give DONE 1 cycle after acceptance with no CALC cycles.
5. Handshake:
   - START with new operands at cycle 10 of a MUL → ignored; the original result is returned.
   - START in the DONE cycle → accepted; the second DONE arrives 33 cycles later.
6. Reset mid-operation: assert RESET at cycle 15 of a DIV → BUSY=0, DONE=0 and RESULT=0 immediately; no DONE follows. A subsequent MUL 3×4 → 12.
   - With MDU_EARLY_OUT_EN defined: MUL 7×1 gives DONE after 2 cycles with RESULT=7.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: RISC-V M funct3
// encodings, FSM state encoding and the default operand width.
package mdu_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_t;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift remainder:quotient
// left, trial-subtract the divisor, keep the difference and set the quotient bit if it fits.
module mdu_div_step
   import mdu_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [XLEN-1:0] rem,
   input  logic [XLEN-1:0] quot,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_next,
   output logic [XLEN-1:0] quot_next
);

   logic [XLEN:0] rem_sh;
   logic [XLEN:0] diff;

   // rem < divisor always holds, so the shifted remainder fits in XLEN+1 bits
   // and the top bit of the difference is a clean borrow flag.
   assign rem_sh = {rem, quot[XLEN-1]};
   assign diff   = rem_sh - {1'b0, divisor};

   always_comb begin
      if (!diff[XLEN]) begin
         rem_next  = diff[XLEN-1:0];
         quot_next = {quot[XLEN-2:0], 1'b1};
      end else begin
         rem_next  = rem_sh[XLEN-1:0];
         quot_next = {quot[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RISC-V M-extension unit (radix-2 shift-add multiply, restoring divide).
// Optional macro MDU_EARLY_OUT_EN lets a multiply finish once its remaining multiplier bits are zero.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter  int XLEN  = XLEN_DEF,
   localparam int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            START,
   input  logic [2:0]      SELECT,
   input  logic [XLEN-1:0] DATA1,
   input  logic [XLEN-1:0] DATA2,
   output logic            BUSY,
   output logic            DONE,
   output logic [XLEN-1:0] RESULT
);

   state_t              state;
   logic [2:0]          op;
   logic                sign_a;
   logic                sign_b;
   logic                special;
   logic [XLEN-1:0]     mcand;
   logic [2*XLEN-1:0]   acc;
   logic [CNT_W-1:0]    cnt;

   logic                signed_a, signed_b, neg_a, neg_b;
   logic                div_zero, div_ovf, is_special;
   logic [XLEN-1:0]     mag_a, mag_b, special_val;

   // Operand decode in IDLE: sign handling and divide special cases.
   always_comb begin
      signed_a    = (SELECT == OP_MULH) || (SELECT == OP_MULHSU) ||
                    (SELECT == OP_DIV)  || (SELECT == OP_REM);
      signed_b    = (SELECT == OP_MULH) || (SELECT == OP_DIV) || (SELECT == OP_REM);
      neg_a       = signed_a & DATA1[XLEN-1];
      neg_b       = signed_b & DATA2[XLEN-1];
      mag_a       = neg_a ? -DATA1 : DATA1;
      mag_b       = neg_b ? -DATA2 : DATA2;
      div_zero    = (DATA2 == '0);
      div_ovf     = SELECT[2] && signed_b &&
                    (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) && (DATA2 == '1);
      is_special  = SELECT[2] && (div_zero || div_ovf);
      special_val = '0;
      if (div_zero) special_val = SELECT[1] ? DATA1 : '1;
      else          special_val = SELECT[1] ? '0 : DATA1;
   end

   logic [XLEN:0]       mul_sum;
   logic [2*XLEN-1:0]   mul_next;
   logic [2*XLEN-1:0]   div_next;
   logic [2*XLEN-1:0]   mul_acc;
   logic                calc_last;

   assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
   assign mul_next = {mul_sum, acc[XLEN-1:1]};

   mdu_div_step #(.XLEN(XLEN)) u_div_step (
      .rem       (acc[2*XLEN-1:XLEN]),
      .quot      (acc[XLEN-1:0]),
      .divisor   (mcand),
      .rem_next  (div_next[2*XLEN-1:XLEN]),
      .quot_next (div_next[XLEN-1:0])
   );

`ifdef MDU_EARLY_OUT_EN
   logic [CNT_W-1:0]    rem_cnt;
   logic [CNT_W-1:0]    keep_sh;
   logic [XLEN-1:0]     rem_bits;
   logic                mul_idle;

   // Once the unconsumed multiplier bits are zero, the remaining iterations
   // would only shift, so do them all at once.
   always_comb begin
      rem_cnt   = cnt - 1'b1;
      keep_sh   = CNT_W'(XLEN) - rem_cnt;
      rem_bits  = mul_next[XLEN-1:0] << keep_sh;
      mul_idle  = (rem_bits == '0);
      mul_acc   = mul_idle ? (mul_next >> rem_cnt) : mul_next;
      calc_last = (cnt == CNT_W'(1)) || (!op[2] && mul_idle);
   end
`else
   always_comb begin
      mul_acc   = mul_next;
      calc_last = (cnt == CNT_W'(1));
   end
`endif

   logic [2*XLEN-1:0]   prod;
   logic [XLEN-1:0]     quot_s, rem_s, fin_val;

   always_comb begin
      prod    = (sign_a ^ sign_b) ? -acc : acc;
      quot_s  = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem_s   = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      fin_val = '0;
      if (special) begin
         fin_val = acc[XLEN-1:0];
      end else begin
         case (op)
            OP_MUL:                       fin_val = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_val = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fin_val = quot_s;
            default:                      fin_val = rem_s;
         endcase
      end
   end

   assign BUSY = (state != IDLE);

   // START is only looked at in IDLE, so captured operands are stable while busy.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state   <= IDLE;
         op      <= '0;
         sign_a  <= 1'b0;
         sign_b  <= 1'b0;
         special <= 1'b0;
         mcand   <= '0;
         acc     <= '0;
         cnt     <= '0;
         RESULT  <= '0;
         DONE    <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            IDLE: begin
               if (START) begin
                  op      <= SELECT;
                  sign_a  <= neg_a;
                  sign_b  <= neg_b;
                  special <= is_special;
                  mcand   <= SELECT[2] ? mag_b : mag_a;
                  if (is_special) begin
                     acc   <= {{XLEN{1'b0}}, special_val};
                     state <= FIN;
                  end else begin
                     acc   <= {{XLEN{1'b0}}, (SELECT[2] ? mag_a : mag_b)};
                     cnt   <= CNT_W'(XLEN);
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               cnt <= cnt - 1'b1;
               acc <= op[2] ? div_next : mul_acc;
               if (calc_last) state <= FIN;
            end
            FIN: begin
               RESULT <= fin_val;
               DONE   <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit (XLEN=32): directed tables, handshake/reset scenarios and
// randomized operations checked against a plain-arithmetic reference model.
module tb_mul_div_unit;

   logic        CLK;
   logic        RESET;
   logic        START;
   logic [2:0]  SELECT;
   logic [31:0] DATA1;
   logic [31:0] DATA2;
   logic        BUSY;
   logic        DONE;
   logic [31:0] RESULT;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_q[$];

   mul_div_unit dut (
      .CLK    (CLK),
      .RESET  (RESET),
      .START  (START),
      .SELECT (SELECT),
      .DATA1  (DATA1),
      .DATA2  (DATA2),
      .BUSY   (BUSY),
      .DONE   (DONE),
      .RESULT (RESULT)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // reference model: RISC-V M semantics in 64-bit arithmetic
   function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint     sa, sb, ua;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, b});
      p  = '0;
      case (op)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ua; return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            p = sa / sb; return p[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op[2] && b == 0) return 1;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 15));
         4: return -32'($urandom_range(1, 15));
         default: return $urandom;
      endcase
   endfunction

   // driver: called at a negedge; returns at the negedge of the DONE cycle.
   // intr_at > 0 raises START with junk operands during that busy cycle.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int intr_at, output logic [31:0] res, output int lat, output int busy_cyc);
      bit seen;
      START  = 1'b1;
      SELECT = op;
      DATA1  = a;
      DATA2  = b;
      @(posedge CLK);
      @(negedge CLK);
      START    = 1'b0;
      SELECT   = 3'($urandom);
      DATA1    = $urandom;
      DATA2    = $urandom;
      busy_cyc = BUSY ? 1 : 0;
      lat      = 100;
      res      = 'x;
      seen     = 1'b0;
      for (int i = 1; i <= 100 && !seen; i++) begin
         START = (i == intr_at);
         if (i == intr_at) begin
            SELECT = 3'($urandom);
            DATA1  = $urandom;
            DATA2  = $urandom;
         end
         @(posedge CLK);
         @(negedge CLK);
         START = 1'b0;
         if (DONE) begin
            seen = 1'b1;
            lat  = i;
            res  = RESULT;
         end else if (BUSY) begin
            busy_cyc++;
         end
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      #1;
      n_tests++;
      if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", BUSY); end
      repeat (3) @(negedge CLK);
      n_tests++;
      if (DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", DONE); end
      n_tests++;
      if (RESULT !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", RESULT); end
      RESET = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_mul_basic();
      logic [31:0] res; int lat, bc;
      do_op(3'd0, 32'd20, 32'd10, 0, res, lat, bc);
      n_tests++;
      if (res !== 32'h0000_00C8) begin n_fail++; $display("FAIL mul_basic_result: got %h want 000000c8", res); end
      n_tests++;
      if (lat !== 33) begin n_fail++; $display("FAIL mul_basic_latency: got %0d want 33", lat); end
      n_tests++;
      if (bc !== 33) begin n_fail++; $display("FAIL mul_basic_busy_cycles: got %0d want 33", bc); end
      @(negedge CLK);
      n_tests++;
      if (DONE !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b want 0", DONE); end
      n_tests++;
      if (RESULT !== 32'h0000_00C8) begin n_fail++; $display("FAIL result_hold: got %h want 000000c8", RESULT); end
   endtask

   // directed table: MULH/MULHSU/MULHU/MUL, signed/unsigned divide, special cases
   task automatic test_directed();
      logic [2:0]  t_op  [12] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd4, 3'd6, 3'd5, 3'd7,
                                  3'd5, 3'd7, 3'd4, 3'd6};
      logic [31:0] t_a   [12] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                  32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] t_b   [12] = '{32'd3, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'd2, 32'd2, 32'd2, 32'd2,
                                  32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] t_exp [12] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
                                  32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h0000_0001,
                                  32'hFFFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'h0000_0000};
      int          t_lat [12] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
      logic [31:0] res; int lat, bc;
      for (int i = 0; i < 12; i++) begin
         do_op(t_op[i], t_a[i], t_b[i], 0, res, lat, bc);
         n_tests++;
         if (res !== t_exp[i]) begin
            n_fail++; $display("FAIL directed_%0d_result: op %0d got %h want %h", i, t_op[i], res, t_exp[i]);
         end
         n_tests++;
         if (lat !== t_lat[i]) begin
            n_fail++; $display("FAIL directed_%0d_latency: got %0d want %0d", i, lat, t_lat[i]);
         end
      end
   endtask

   task automatic test_start_while_busy();
      logic [31:0] res; int lat, bc;
      do_op(3'd0, 32'd20, 32'd10, 10, res, lat, bc);
      n_tests++;
      if (res !== 32'd200) begin n_fail++; $display("FAIL busy_start_result: got %h want 000000c8", res); end
      n_tests++;
      if (lat !== 33) begin n_fail++; $display("FAIL busy_start_latency: got %0d want 33", lat); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r1, r2; int l1, l2, bc;
      do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, r1, l1, bc);
      do_op(3'd5, 32'd100, 32'd7, 0, r2, l2, bc);
      n_tests++;
      if (r1 !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL b2b_first_result: got %h want fffffffe", r1); end
      n_tests++;
      if (r2 !== 32'd14) begin n_fail++; $display("FAIL b2b_second_result: got %h want 0000000e", r2); end
      n_tests++;
      if (l2 !== 33) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want 33", l2); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] res; int lat, bc, dones;
      do_op(3'd0, 32'd5, 32'd5, 0, res, lat, bc);
      n_tests++;
      if (res !== 32'd25) begin n_fail++; $display("FAIL pre_reset_result: got %h want 00000019", res); end
      START = 1'b1; SELECT = 3'd4; DATA1 = 32'd1000; DATA2 = 32'd7;
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0;
      repeat (14) @(negedge CLK);
      RESET = 1'b1;
      #1;
      n_tests++;
      if (BUSY !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b want 0", BUSY); end
      n_tests++;
      if (DONE !== 1'b0) begin n_fail++; $display("FAIL mid_reset_done: got %b want 0", DONE); end
      n_tests++;
      if (RESULT !== 32'h0) begin n_fail++; $display("FAIL mid_reset_result: got %h want 0", RESULT); end
      @(negedge CLK);
      RESET = 1'b0;
      dones = 0;
      repeat (40) begin
         @(negedge CLK);
         if (DONE) dones++;
      end
      n_tests++;
      if (dones !== 0) begin n_fail++; $display("FAIL mid_reset_no_done: got %0d pulses want 0", dones); end
      do_op(3'd0, 32'd3, 32'd4, 0, res, lat, bc);
      n_tests++;
      if (res !== 32'd12) begin n_fail++; $display("FAIL post_reset_mul: got %h want 0000000c", res); end
   endtask

`ifdef MDU_EARLY_OUT_EN
   task automatic test_early_out();
      logic [31:0] res; int lat, bc;
      do_op(3'd0, 32'd7, 32'd1, 0, res, lat, bc);
      n_tests++;
      if (res !== 32'd7) begin n_fail++; $display("FAIL early_out_result: got %h want 00000007", res); end
      n_tests++;
      if (lat !== 2) begin n_fail++; $display("FAIL early_out_latency: got %0d want 2", lat); end
   endtask
`endif

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] a, b, res, exp_v;
      int          lat, bc, want_lat;
      for (int i = 0; i < 200; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = rand_operand();
         b  = rand_operand();
         exp_q.push_back(ref_mdu(op, a, b));
         want_lat = ref_lat(op, a, b);
         do_op(op, a, b, 0, res, lat, bc);
         exp_v = exp_q.pop_front();
         n_tests++;
         if (res !== exp_v) begin
            n_fail++; $display("FAIL random_%0d_result: op %0d a %h b %h got %h want %h", i, op, a, b, res, exp_v);
         end
`ifdef MDU_EARLY_OUT_EN
         if (!op[2]) begin
            n_tests++;
            if (lat < 2 || lat > 33) begin
               n_fail++; $display("FAIL random_%0d_latency: got %0d want 2..33", i, lat);
            end
         end else begin
            n_tests++;
            if (lat !== want_lat) begin
               n_fail++; $display("FAIL random_%0d_latency: got %0d want %0d", i, lat, want_lat);
            end
         end
`else
         n_tests++;
         if (lat !== want_lat) begin
            n_fail++; $display("FAIL random_%0d_latency: got %0d want %0d", i, lat, want_lat);
         end
`endif
         repeat ($urandom_range(0, 2)) @(negedge CLK);
      end
   endtask

   initial begin
      RESET  = 1'b1;
      START  = 1'b0;
      SELECT = 3'd0;
      DATA1  = '0;
      DATA2  = '0;
      test_reset();
      test_mul_basic();
      test_directed();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid();
`ifdef MDU_EARLY_OUT_EN
      test_early_out();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
